imm_gen_fifo: RTL

- Parametrised, registered immediate generator for the RV32I datapath; successor to the combinational 2-bit-select immediate extender.
- Covers all base immediate formats (I, S, B, U, J, I-shamt) and sign-extends to XLEN.
- Output is buffered in a DEPTH-entry FIFO with valid/ready on both sides, so decode can run ahead of a stalled execute stage.
- A tag travels with each immediate so the consumer can match the result to its instruction.

---
 rtl/imm_gen_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/imm_gen_fifo.sv
// imm_gen_fifo: registered RV32I immediate generator feeding a DEPTH-entry valid/ready FIFO.
// Ports: clk, rst (synchronous, active-high);
//        producer side in_valid/in_ready, in_instr, in_immsrc (0 I,1 S,2 B,3 U,4 J,5 I-shamt), in_tag;
//        consumer side out_valid/out_ready, out_imm, out_tag (both zero while empty or in reset).
// Optional: define IMM_GEN_ERR_EN to add out_err, flagging reserved formats and RV32-illegal shift amounts.
module imm_gen_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
`ifdef IMM_GEN_ERR_EN
   output logic             out_err,
`endif
   output logic [TAG_W-1:0] out_tag
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [XLEN-1:0] imm_mem_q [DEPTH];
   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   logic [31:0] fmt;
   logic [XLEN-1:0] imm;
   logic sext, push, pop;
   logic unused_opcode;
   assign unused_opcode = ^in_instr[6:0];
   always_comb begin
      fmt = in_immsrc == 3'd0 ? {{20{in_instr[31]}}, in_instr[31:20]}
          : in_immsrc == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
          : in_immsrc == 3'd2 ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
          : in_immsrc == 3'd3 ? {in_instr[31:12], 12'b0}
          : in_immsrc == 3'd4 ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
          : in_immsrc == 3'd5 ? {27'b0, in_instr[24:20]}
          : 32'b0;
      // shamt and reserved codes are zero-extended; every real format extends from bit 31
      sext = in_immsrc < 3'd5;
      imm = sext ? XLEN'($signed(fmt)) : XLEN'(fmt);
   end
   // reset gates the handshake so nothing is accepted or presented in the reset cycle itself
   assign in_ready  = !rst && count_q != FULL;
   assign out_valid = !rst && count_q != '0;
   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;
   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem_q[wr_ptr_q] <= imm;
         tag_mem_q[wr_ptr_q] <= in_tag;
      end
   end
   assign out_imm = out_valid ? imm_mem_q[rd_ptr_q] : '0;
   assign out_tag = out_valid ? tag_mem_q[rd_ptr_q] : '0;
`ifdef IMM_GEN_ERR_EN
   logic err_mem_q [DEPTH];
   logic err;
   assign err = in_immsrc[2:1] == 2'b11 || (in_immsrc == 3'd5 && in_instr[25] && XLEN == 32);
   always_ff @(posedge clk) begin
      if (push) err_mem_q[wr_ptr_q] <= err;
   end
   assign out_err = out_valid && err_mem_q[rd_ptr_q];
`endif
endmodule
